bit_serializer: RTL and testbench

Parallel-to-serial stage upstream of the 1101 pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and holds each in a one-word buffer. It then shifts the word out one bit per clk on o, which drives the detector's serial input i. With the buffer refilled in time, consecutive words stream with no idle gap between them.

---
 rtl/bit_serializer_if.sv | 14 +
 rtl/bit_serializer.sv | 61 ++++++
 tb/tb_bit_serializer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake and serial output bundle of the serializer
//   din/din_valid/din_ready : parallel word handshake (source drives din, din_valid)
//   o/o_valid               : registered serial bit and its qualifier
//   busy                    : a word is buffered or being shifted
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic o;
  logic o_valid;
  logic busy;
  modport master(output din, din_valid, input din_ready, o, o_valid, busy);
  modport slave(input din, din_valid, output din_ready, o, o_valid, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: one-word buffered parallel-to-serial shifter, gapless when refilled in time
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of bit_serializer_if (din/din_valid in, din_ready/o/o_valid/busy out)
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input logic clk,
  input logic rst,
  bit_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0] cnt;
  logic hold_full;
  logic o_r;
  logic o_valid_r;
  logic accept;
  logic load;
  // A load happens from IDLE or as the last bit leaves; the two never coincide with an accept.
  assign accept = bus.din_valid & ~hold_full;
  assign load = hold_full & (state == IDLE || cnt == '0);
  assign bus.din_ready = ~hold_full;
  assign bus.busy = hold_full | o_valid_r;
  assign bus.o = o_r;
  assign bus.o_valid = o_valid_r;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      cnt       <= '0;
      o_r       <= IDLE_BIT;
      o_valid_r <= 1'b0;
    end else begin
      if (accept) hold <= bus.din;
      hold_full <= accept | (hold_full & ~load);
      if (load) begin
        shift_reg <= hold;
        cnt       <= CW'(WIDTH - 1);
        o_r       <= MSB_FIRST ? hold[WIDTH-1] : hold[0];
        o_valid_r <= 1'b1;
        state     <= SHIFT;
      end else if (state == SHIFT && cnt != '0) begin
        shift_reg <= MSB_FIRST ? shift_reg << 1 : shift_reg >> 1;
        cnt       <= cnt - 1'b1;
        o_r       <= MSB_FIRST ? shift_reg[WIDTH-2] : shift_reg[1];
      end else begin
        o_r       <= IDLE_BIT;
        o_valid_r <= 1'b0;
        state     <= IDLE;
      end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed check of MSB- and LSB-first serializers against a queue model
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] d = '0;
  logic dv = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mh [2];
  logic mhf [2];
  bit bq [2][$];
  logic last_acc;
  int run, maxrun;
  logic [7:0] cap_a, cap_b;
  always #5 clk = ~clk;
  bit_serializer_if #(.WIDTH(8)) ifa ();
  bit_serializer_if #(.WIDTH(8)) ifb ();
  assign ifa.din = d;
  assign ifa.din_valid = dv;
  assign ifb.din = d;
  assign ifb.din_valid = dv;
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mhf[k] = 1'b0;
      bq[k].delete();
    end
  endtask
  task automatic check_outputs();
    logic ev;
    logic eo;
    for (int k = 0; k < 2; k++) begin
      ev = bq[k].size() > 0;
      eo = ev ? bq[k][0] : 1'b0;
      chk(k == 0 ? "a_o_valid" : "b_o_valid", k == 0 ? ifa.o_valid : ifb.o_valid, ev);
      chk(k == 0 ? "a_o" : "b_o", k == 0 ? ifa.o : ifb.o, eo);
      chk(k == 0 ? "a_din_ready" : "b_din_ready", k == 0 ? ifa.din_ready : ifb.din_ready, !mhf[k]);
      chk(k == 0 ? "a_busy" : "b_busy", k == 0 ? ifa.busy : ifb.busy, mhf[k] | ev);
    end
  endtask
  task automatic step();
    logic acc;
    bit dummy;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      acc = dv & !mhf[k];
      if (k == 0) last_acc = acc;
      if (bq[k].size() > 1) dummy = bq[k].pop_front();
      else begin
        bq[k].delete();
        if (mhf[k]) begin
          for (int i = 0; i < 8; i++) bq[k].push_back(k == 0 ? mh[k][7-i] : mh[k][i]);
          mhf[k] = 1'b0;
        end
      end
      if (acc) begin
        mh[k] = d;
        mhf[k] = 1'b1;
      end
    end
    #1;
    check_outputs();
    run = ifa.o_valid ? run + 1 : 0;
    if (run > maxrun) maxrun = run;
    if (ifa.o_valid) cap_a = {cap_a[6:0], ifa.o};
    if (ifb.o_valid) cap_b = {cap_b[6:0], ifb.o};
  endtask
  task automatic idle(input int n);
    dv = 1'b0;
    repeat (n) step();
  endtask
  initial begin
    model_clear();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(20);
    d = 8'hD0; dv = 1'b1;
    step();
    cap_a = '0;
    idle(12);
    chk("single_d0_stream", cap_a, 8'hD0);
    run = 0; maxrun = 0;
    d = 8'hD0; dv = 1'b1;
    step();
    chk("b2b_ready_e0", ifa.din_ready, 1'b0);
    d = 8'h0D;
    step();
    chk("b2b_ready_e1", ifa.din_ready, 1'b1);
    step();
    chk("b2b_accept_e2", last_acc, 1'b1);
    idle(20);
    chk("b2b_gapless_run", maxrun, 16);
    d = 8'h0B; dv = 1'b1;
    step();
    cap_b = '0;
    idle(12);
    chk("lsb_0b_stream", cap_b, 8'hD0);
    d = 8'h55; dv = 1'b1;
    step();
    step();
    d = 8'h33;
    step();
    d = 8'hAA;
    step();
    chk("bp_ready_low", ifa.din_ready, 1'b0);
    chk("bp_not_taken", last_acc, 1'b0);
    begin
      int budget = 30;
      while (!last_acc && budget > 0) begin
        step();
        budget--;
      end
      chk("bp_aa_accepted", last_acc, 1'b1);
    end
    idle(20);
    d = 8'hFF; dv = 1'b1;
    step();
    dv = 1'b0;
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    #3 rst = 1'b1;
    idle(12);
    for (int c = 0; c < 400; c++) begin
      dv = ($urandom % 3) != 0;
      d = 8'($urandom);
      step();
    end
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
